// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the datapath FIFO: waits for a full burst, reads it through a
// 4-entry skid buffer that absorbs the FIFO read latency, and streams it out as valid/ready/last.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int WL_WIDTH   = 11,
  parameter int BURST_LEN  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic [WL_WIDTH-1:0]   fifo_water_level,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [15:0]           burst_cnt
);

  localparam int CNT_W     = $clog2(BURST_LEN + 1);
  localparam int BUF_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_e                state_q;
  logic [CNT_W-1:0]      rd_left_q;
  logic                  busy_q;
  logic [15:0]           burst_cnt_q;

  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0] pipe_last_q, pipe_last_d;

  entry_t                mem_q [BUF_DEPTH];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            occ_q, occ_d;

  logic [2:0]            inflight;
  logic                  rd_last;
  logic                  push, push_last, pop;
  entry_t                head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + 3'(pipe_vld_q[i]);
    end
  end

  // A read is only issued when the buffer has room for everything already in flight plus it.
  assign fifo_rd_en = (state_q == BURST) && !fifo_rd_empty && (rd_left_q != '0) &&
                      (({1'b0, occ_q} + {1'b0, inflight}) < 4'(BUF_DEPTH));

  assign rd_last     = (rd_left_q == CNT_W'(1));
  assign pipe_vld_d  = (pipe_vld_q << 1)  | RD_LATENCY'(fifo_rd_en);
  assign pipe_last_d = (pipe_last_q << 1) | RD_LATENCY'(fifo_rd_en && rd_last);

  assign push      = pipe_vld_q[RD_LATENCY-1];
  assign push_last = pipe_last_q[RD_LATENCY-1];
  assign head      = mem_q[rd_ptr_q];
  assign m_valid   = (occ_q != '0);
  assign pop       = m_valid && m_ready;

  assign m_data    = head.data;
  assign m_last    = m_valid && head.last;
  assign busy      = busy_q;
  assign burst_cnt = burst_cnt_q;

  always_comb begin
    // NOTE: default assignment first so no branch leaves occ_d unassigned and infers a latch.
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_left_q   <= '0;
      busy_q      <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && (fifo_water_level >= WL_WIDTH'(BURST_LEN))) begin
            state_q   <= BURST;
            rd_left_q <= CNT_W'(BURST_LEN);
            busy_q    <= 1'b1;
          end
        end
        BURST: begin
          if (fifo_rd_en) begin
            rd_left_q <= rd_left_q - CNT_W'(1);
            if (rd_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            burst_cnt_q <= burst_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      // NOTE: the buffer entries are cleared too, so m_data reads 0 straight out of reset.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      occ_q       <= occ_d;
      if (push) begin
        mem_q[wr_ptr_q] <= entry_t'{last: push_last, data: fifo_rd_data};
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
    end
  end

endmodule
